uart_dev: RTL
=============

UART_DEV -- requirements
Module: uart_dev

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port Addr, input, 3, word index: 0 DATA, 1 IER, 2 LSR, 3 DIVR, 4 DIVT, 5-7 reserved.
REQ-004 SHALL have port WE, input, 1, write strobe for the addressed register, one cycle per write.
REQ-005 SHALL have port WD, input, 32, write data.
REQ-006 SHALL have port RD, output, 32, combinational read data of the addressed register; reads have no side effects.
REQ-007 SHALL have port IRQ, output, 1, level interrupt request to the bus decoder.
REQ-008 SHALL have port uart_rxd, input, 1, asynchronous serial input, idle high.
REQ-009 SHALL have port uart_txd, output, 1, serial output, idle high.

Function
REQ-010 SHALL decode registers as follows:
- DATA: write = TX byte WD[7:0]; read = {24'd0, RXBUF}.
- IER: bit0 RX-valid enable, bit1 TX-done enable.
- LSR: bit0 rx_valid, bit1 overrun, bit2 tx_busy, bit3 frame_err, bit4 parity_err, bit5 tx_done; bits 0,1,3,4,5 write-1-to-clear; bit2 read-only.
- DIVR/DIVT: RX/TX clocks-per-bit, 16 bits.
- Reserved reads: 0.
REQ-011 SHALL treat a divisor value of 0 or 1 as 2.
REQ-012 SHALL run TX FSM states IDLE, START, DATA, PARITY (macro only), STOP; each state lasts DIVT cycles; data bits go LSB first.
REQ-013 SHALL on a DATA write in IDLE load the shifter, set tx_busy and clear tx_done in the same edge; uart_txd goes low at the next edge.
REQ-014 SHALL ignore a DATA write while tx_busy=1 (byte dropped, no flag change).
REQ-015 SHALL at the end of STOP clear tx_busy, set tx_done and return to IDLE; back-to-back transmission requires a new write.
REQ-016 SHALL pass uart_rxd through a 2-flop synchronizer before any use.
REQ-017 SHALL run RX FSM states IDLE, START, DATA, PARITY (macro only), STOP; the synchronized falling edge enters START; mid-bit (DIVR/2 cycles) sampling confirms start, else returns to IDLE (glitch rejection); subsequent samples are taken every DIVR cycles.
REQ-018 SHALL on a stop sample of 0 set frame_err and discard the byte (rx_valid unchanged).
REQ-019 SHALL on a valid byte with rx_valid=0 load RXBUF and set rx_valid.
REQ-020 SHALL on a valid byte with rx_valid=1 keep the old RXBUF and set overrun.
REQ-021 SHALL on a same-cycle W1C of a flag and hardware set of that flag leave the flag set (set wins).
REQ-022 SHALL drive IRQ = (IER[0] & rx_valid) | (IER[1] & tx_done), combinationally from the registered flags.
REQ-023 SHALL apply a DIVR/DIVT write mid-frame from the next bit boundary; the frame in progress is not aborted.

Reset
REQ-024 SHALL on RST low asynchronously force: both FSMs IDLE, uart_txd=1, IRQ=0, all LSR flags 0, IER=0, RXBUF=0, DIVR=DIVT=434, synchronizer flops=1.
REQ-025 SHALL when reset is asserted mid-frame abandon the frame with no flag set after release; RX then waits for a fresh falling edge.

Configuration
REQ-026 SHALL with UART_PARITY_EN defined send an even-parity bit after bit 7 and check the received one; on a mismatch set parity_err and discard the byte (as REQ-018).
REQ-027 SHALL without UART_PARITY_EN use 8N1, omit the PARITY states, and read LSR bit4 as 0.

Structure
REQ-028 SHALL place in the shared package: register index constants, LSR bit positions, IER bit positions, reset divisor 434, and the FSM state enums.
REQ-029 SHALL implement the bit-period down-counter as one sub-module, uart_bit_timer (load, tick, half-period option), instantiated once for TX and once for RX.

Verification
REQ-030 SHALL cover TX: DIVT=4, write DATA=0x5A -> txd low 4 cycles, then 0,1,0,1,1,0,1,0 each 4 cycles, then high; tx_done=1 at frame end; IRQ=1 with IER=2.
REQ-031 SHALL cover RX loopback: DIVR=8, drive 0xA5 -> RXBUF=0xA5, rx_valid=1, IRQ=1 with IER=1; write LSR=0x01 -> rx_valid=0, IRQ=0.
REQ-032 SHALL cover overrun: two bytes 0x11 then 0x22 without clearing -> RXBUF=0x11, LSR=0x03.
REQ-033 SHALL cover a glitch and a frame error: a 2-cycle low pulse -> no flags; a frame with stop=0 -> frame_err=1, rx_valid=0.
REQ-034 SHALL cover a write while busy: DATA=0x33 then DATA=0x44 mid-frame -> only 0x33 transmitted.
REQ-035 SHALL cover reset mid-frame: RST low during RX bit 3 and TX bit 5 -> txd=1, LSR=0, DIVR=DIVT=434 immediately, no flags after release.

Source files
------------

// File: rtl/uart_dev_pkg.sv
// Shared constants and FSM state types for uart_dev.
// UART_PARITY_EN adds the PARITY states (8E1 framing); undefined gives 8N1.
package uart_dev_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_IER  = 3'd1;
  localparam logic [2:0] ADDR_LSR  = 3'd2;
  localparam logic [2:0] ADDR_DIVR = 3'd3;
  localparam logic [2:0] ADDR_DIVT = 3'd4;

  localparam int unsigned LSR_RX_VALID   = 0;
  localparam int unsigned LSR_OVERRUN    = 1;
  localparam int unsigned LSR_TX_BUSY    = 2;
  localparam int unsigned LSR_FRAME_ERR  = 3;
  localparam int unsigned LSR_PARITY_ERR = 4;
  localparam int unsigned LSR_TX_DONE    = 5;

  localparam int unsigned IER_RX_VALID = 0;
  localparam int unsigned IER_TX_DONE  = 1;

  localparam logic [15:0] DIV_RESET = 16'd434;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
`ifdef UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
`ifdef UART_PARITY_EN
    RxParity,
`endif
    RxStop
  } rx_state_e;

  // Divisors below 2 would give a zero-length half period.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: ticks every divisor cycles, reloading itself on the tick
// so a divisor change takes effect at the next bit boundary.
module uart_bit_timer
  import uart_dev_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_half,
  input  logic [15:0] i_div,
  output logic        o_tick
);

  logic [15:0] w_eff;
  logic [15:0] w_load_val;
  logic [15:0] r_cnt;

  assign w_eff      = eff_div(i_div);
  assign w_load_val = (i_half ? (w_eff >> 1) : w_eff) - 16'd1;
  assign o_tick     = (r_cnt == 16'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 16'd0;
    end else if (i_load) begin
      r_cnt <= w_load_val;
    end else if (r_cnt == 16'd0) begin
      r_cnt <= w_eff - 16'd1;
    end else begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

endmodule

// File: rtl/uart_dev.sv
// uart_dev: register-mapped UART with TX/RX FSMs, W1C status flags and a level IRQ.
// Define UART_PARITY_EN for even parity (sent and checked); default build is 8N1.
module uart_dev
  import uart_dev_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  logic [1:0]  r_ier;
  logic [15:0] r_divr, r_divt;
  logic [7:0]  r_rxbuf;
  logic        r_rx_valid, r_overrun, r_frame_err, r_tx_done;
  logic        w_parity_err, w_wr_lsr, w_unused;
  logic [31:0] w_lsr;

  tx_state_e   r_tx_state, w_tx_state_d;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_bitcnt;
  logic        r_txd, w_txd_d, w_tx_start, w_tx_tick, w_tx_done_set;

  rx_state_e   r_rx_state, w_rx_state_d;
  logic [1:0]  r_sync;
  logic [7:0]  r_rx_shift;
  logic [2:0]  r_rx_bitcnt;
  logic        r_rx_prev, w_rxs, w_rx_load, w_rx_tick, w_byte_ok, w_ferr_set;
`ifdef UART_PARITY_EN
  logic        r_tx_par, r_rx_par, r_parity_err, w_perr_set;
  assign w_parity_err = r_parity_err;
`else
  assign w_parity_err = 1'b0;
`endif

  assign w_wr_lsr   = WE && (Addr == ADDR_LSR);
  assign w_tx_start = WE && (Addr == ADDR_DATA) && (r_tx_state == TxIdle);
  assign w_rxs      = r_sync[1];
  assign w_unused   = ^WD[31:16];
  assign uart_txd   = r_txd;
  assign IRQ        = (r_ier[IER_RX_VALID] & r_rx_valid) | (r_ier[IER_TX_DONE] & r_tx_done);

  uart_bit_timer u_tx_timer (
    .i_clk(CLK), .i_rst_n(RST), .i_load(w_tx_start), .i_half(1'b0), .i_div(r_divt),
    .o_tick(w_tx_tick)
  );

  uart_bit_timer u_rx_timer (
    .i_clk(CLK), .i_rst_n(RST), .i_load(w_rx_load), .i_half(1'b1), .i_div(r_divr),
    .o_tick(w_rx_tick)
  );

  always_comb begin
    w_tx_state_d  = r_tx_state;
    w_tx_done_set = 1'b0;
    w_txd_d       = 1'b1;
    case (r_tx_state)
      TxIdle:  if (w_tx_start) w_tx_state_d = TxStart;
      TxStart: begin
        w_txd_d = 1'b0;
        if (w_tx_tick) w_tx_state_d = TxData;
      end
      TxData: begin
        w_txd_d = r_tx_shift[0];
`ifdef UART_PARITY_EN
        if (w_tx_tick && r_tx_bitcnt == 3'd7) w_tx_state_d = TxParity;
      end
      TxParity: begin
        w_txd_d = r_tx_par;
        if (w_tx_tick) w_tx_state_d = TxStop;
`else
        if (w_tx_tick && r_tx_bitcnt == 3'd7) w_tx_state_d = TxStop;
`endif
      end
      TxStop: if (w_tx_tick) begin
        w_tx_state_d  = TxIdle;
        w_tx_done_set = 1'b1;
      end
      default: w_tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_load    = 1'b0;
    w_byte_ok    = 1'b0;
    w_ferr_set   = 1'b0;
`ifdef UART_PARITY_EN
    w_perr_set   = 1'b0;
`endif
    case (r_rx_state)
      RxIdle: if (r_rx_prev && !w_rxs) begin
        w_rx_state_d = RxStart;
        w_rx_load    = 1'b1;
      end
      // Mid-bit check of the start bit rejects short glitches.
      RxStart: if (w_rx_tick) w_rx_state_d = w_rxs ? RxIdle : RxData;
`ifdef UART_PARITY_EN
      RxData:   if (w_rx_tick && r_rx_bitcnt == 3'd7) w_rx_state_d = RxParity;
      RxParity: if (w_rx_tick) w_rx_state_d = RxStop;
`else
      RxData:   if (w_rx_tick && r_rx_bitcnt == 3'd7) w_rx_state_d = RxStop;
`endif
      RxStop: if (w_rx_tick) begin
        w_rx_state_d = RxIdle;
        if (!w_rxs) w_ferr_set = 1'b1;
`ifdef UART_PARITY_EN
        else if (r_rx_par) w_perr_set = 1'b1;
`endif
        else w_byte_ok = 1'b1;
      end
      default: w_rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tx_state  <= TxIdle;
      r_tx_shift  <= 8'd0;
      r_tx_bitcnt <= 3'd0;
      r_txd       <= 1'b1;
      r_rx_state  <= RxIdle;
      r_sync      <= 2'b11;
      r_rx_prev   <= 1'b1;
      r_rx_shift  <= 8'd0;
      r_rx_bitcnt <= 3'd0;
`ifdef UART_PARITY_EN
      r_tx_par    <= 1'b0;
      r_rx_par    <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state_d;
      r_txd      <= w_txd_d;
      r_rx_state <= w_rx_state_d;
      r_sync     <= {r_sync[0], uart_rxd};
      r_rx_prev  <= w_rxs;
      if (w_tx_start) begin
        r_tx_shift  <= WD[7:0];
        r_tx_bitcnt <= 3'd0;
`ifdef UART_PARITY_EN
        r_tx_par    <= ^WD[7:0];
`endif
      end else if (r_tx_state == TxData && w_tx_tick) begin
        r_tx_shift  <= r_tx_shift >> 1;
        r_tx_bitcnt <= r_tx_bitcnt + 3'd1;
      end
      if (w_rx_load) begin
        r_rx_bitcnt <= 3'd0;
`ifdef UART_PARITY_EN
        r_rx_par    <= 1'b0;
`endif
      end else if (r_rx_state == RxData && w_rx_tick) begin
        r_rx_shift  <= {w_rxs, r_rx_shift[7:1]};
        r_rx_bitcnt <= r_rx_bitcnt + 3'd1;
`ifdef UART_PARITY_EN
        r_rx_par    <= r_rx_par ^ w_rxs;
      end else if (r_rx_state == RxParity && w_rx_tick) begin
        r_rx_par    <= r_rx_par ^ w_rxs;
`endif
      end
    end
  end

  // Flags: W1C clear first, hardware set ORed in last so a same-cycle set wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ier        <= 2'd0;
      r_divr       <= DIV_RESET;
      r_divt       <= DIV_RESET;
      r_rxbuf      <= 8'd0;
      r_rx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_tx_done    <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (WE && Addr == ADDR_IER)  r_ier  <= WD[1:0];
      if (WE && Addr == ADDR_DIVR) r_divr <= WD[15:0];
      if (WE && Addr == ADDR_DIVT) r_divt <= WD[15:0];
      if (w_byte_ok && !r_rx_valid) r_rxbuf <= r_rx_shift;
      r_rx_valid  <= (r_rx_valid & ~(w_wr_lsr & WD[LSR_RX_VALID])) | (w_byte_ok & ~r_rx_valid);
      r_overrun   <= (r_overrun & ~(w_wr_lsr & WD[LSR_OVERRUN])) | (w_byte_ok & r_rx_valid);
      r_frame_err <= (r_frame_err & ~(w_wr_lsr & WD[LSR_FRAME_ERR])) | w_ferr_set;
      r_tx_done   <= (r_tx_done & ~(w_wr_lsr & WD[LSR_TX_DONE]) & ~w_tx_start) | w_tx_done_set;
`ifdef UART_PARITY_EN
      r_parity_err <= (r_parity_err & ~(w_wr_lsr & WD[LSR_PARITY_ERR])) | w_perr_set;
`endif
    end
  end

  always_comb begin
    w_lsr                 = 32'd0;
    w_lsr[LSR_RX_VALID]   = r_rx_valid;
    w_lsr[LSR_OVERRUN]    = r_overrun;
    w_lsr[LSR_TX_BUSY]    = (r_tx_state != TxIdle);
    w_lsr[LSR_FRAME_ERR]  = r_frame_err;
    w_lsr[LSR_PARITY_ERR] = w_parity_err;
    w_lsr[LSR_TX_DONE]    = r_tx_done;
    case (Addr)
      ADDR_DATA: RD = {24'd0, r_rxbuf};
      ADDR_IER:  RD = {30'd0, r_ier};
      ADDR_LSR:  RD = w_lsr;
      ADDR_DIVR: RD = {16'd0, r_divr};
      ADDR_DIVT: RD = {16'd0, r_divt};
      default:   RD = 32'd0;
    endcase
  end

endmodule
